fault_campaign_ctrl: RTL
========================

Name: fault_campaign_ctrl

Overview:
- Drives the per-core inject_error inputs of the three Main_core instances, which are currently tied to 0.
- Runs a campaign of single-core fault injections, rotating the target A -> B -> C -> A.
- After each injection, watches Voter_state for the matching detection and records the outcome and the detection latency.
- Sits beside Voter/Lockstep in the TMR top; it only injects and observes, and never touches memories.

Parameters:
- INTERVAL, 64: idle cycles between the end of one recovery and the next injection (1..65535).
- PULSE_LEN, 1: cycles inject_* is held high per injection (1..15).
- TIMEOUT, 32: maximum cycles from the first inject cycle to detection (PULSE_LEN..255).
- NUM_INJ, 16: injections per campaign (1..255).

Ports:
- clk  input  1  system clock
- rst_in  input  1  asynchronous active-low reset
- enable  input  1  level; high starts/continues the campaign, low aborts it
- core_hold  input  1  high while Lockstep recovery is in progress
- Voter_state  input  3  bit0/bit1/bit2 = core A/B/C outvoted this cycle; 0 = all agree
- inject_A  output  1  fault pulse to core A
- inject_B  output  1  fault pulse to core B
- inject_C  output  1  fault pulse to core C
- busy  output  1  campaign active (any state except IDLE/DONE)
- done  output  1  campaign complete; held until enable goes low
- target  output  2  current target core: 0=A, 1=B, 2=C
- detect_count  output  8  injections detected on the correct core (saturating)
- miss_count  output  8  injections not detected within TIMEOUT (saturating)
- spurious_count  output  8  detections flagged on a non-target core (saturating)
- last_latency  output  8  latency of the most recent detected injection

Behaviour:
- Reset (rst_in=0, asynchronous): state=IDLE; all outputs 0; interval, pulse, latency and injection counters 0; target=0.
- All other state changes occur on the rising edge of clk.
- IDLE: on enable=1 -> WAIT; clear all counts, last_latency and target.
- WAIT:
  - Interval counter increments only when core_hold=0 and Voter_state=0; it freezes otherwise.
  - When the counter reaches INTERVAL-1 -> INJECT; counter clears.
- INJECT:
  - inject_<target> is high for exactly PULSE_LEN cycles; the other two injects stay low.
  - At most one inject_* is high in any cycle.
  - After the pulse -> OBSERVE.
- Latency counter:
  - Starts at 1 in the first INJECT cycle and increments every cycle through INJECT and OBSERVE.
  - It runs during INJECT so that a detection inside the pulse is caught.
- Detection (checked in INJECT and OBSERVE, first match wins):
  - Voter_state[target]=1: detect_count+1; last_latency=latency counter value; -> RECOVER.
  - Otherwise, any other Voter_state bit =1: spurious_count+1; keep observing.
  - Latency counter reaches TIMEOUT with no target detection: miss_count+1; -> RECOVER.
  - Detection and timeout in the same cycle count as a detection.
- RECOVER: wait until core_hold=0 and Voter_state=0 in the same cycle. Then:
  - injection counter +1;
  - target advances (2 wraps to 0);
  - if the injection counter = NUM_INJ -> DONE, else -> WAIT.
- DONE: done=1, busy=0; counts are held. enable=0 -> IDLE, with counts retained until the next start.
- enable=0 in any busy state:
  - inject_* drop to 0 in the same clock edge; -> IDLE.
  - Counts are retained; done stays 0.
- No inject is ever asserted while core_hold=1. If core_hold rises during INJECT, the pulse is truncated and the FSM goes to OBSERVE.
- All counts saturate at 255 and do not wrap.
- Outputs are registered; there is no combinational path from an input to inject_*.

Test Plan:
- Reset mid-INJECT (rst_in low for 1 cycle while inject_A=1) -> inject_A=0 immediately (async); all counts 0; state IDLE.
- Ideal voter model, INTERVAL=4, PULSE_LEN=1, NUM_INJ=3, Voter_state bit set 2 cycles after each pulse -> inject_A, inject_B, inject_C in order; detect_count=3; last_latency=3; done=1.
- Voter_state never asserts, TIMEOUT=8, NUM_INJ=2 -> miss_count=2; each RECOVER entered exactly 8 cycles after the first inject cycle.
- Target=B, Voter_state=3'b100 at latency 2 then 3'b010 at latency 4 -> spurious_count=1, detect_count=1, last_latency=4.
- core_hold held high for 10 cycles during WAIT -> interval counter frozen; injection delayed by exactly 10 cycles; no inject_* while core_hold=1.
- enable dropped during OBSERVE after 5 injections -> busy=0, done=0 next cycle; counts retained; re-raising enable clears counts and starts again at target A.

Source files
------------

// File: rtl/fault_campaign_ctrl.sv
// fault_campaign_ctrl
//   Runs a campaign of single-core fault injections against the three
//   lockstepped Main_core instances. The target rotates A -> B -> C -> A.
//   After each pulse the block watches Voter_state for the matching
//   detection. It records hits, misses and spurious flags, and the latency
//   of the most recent hit. It only drives inject_* and observes the voter.
//
// Ports
//   clk            system clock
//   rst_in         asynchronous active-low reset
//   enable         level; high runs the campaign, low aborts it
//   core_hold      high while Lockstep recovery is in progress
//   Voter_state    bit0/1/2 = core A/B/C outvoted this cycle
//   inject_A/B/C   registered fault pulses, at most one high at a time
//   busy           campaign active (WAIT/INJECT/OBSERVE/RECOVER)
//   done           campaign complete, held until enable drops
//   target         current target core (0=A, 1=B, 2=C)
//   detect_count   correct-core detections (saturating)
//   miss_count     injections not detected within TIMEOUT (saturating)
//   spurious_count detections on a non-target core (saturating)
//   last_latency   latency of the most recent detected injection
module fault_campaign_ctrl #(
  parameter int INTERVAL  = 64,
  parameter int PULSE_LEN = 1,
  parameter int TIMEOUT   = 32,
  parameter int NUM_INJ   = 16
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       enable,
  input  logic       core_hold,
  input  logic [2:0] Voter_state,
  output logic       inject_A,
  output logic       inject_B,
  output logic       inject_C,
  output logic       busy,
  output logic       done,
  output logic [1:0] target,
  output logic [7:0] detect_count,
  output logic [7:0] miss_count,
  output logic [7:0] spurious_count,
  output logic [7:0] last_latency
);

  localparam logic [15:0] IVL_LAST  = 16'(INTERVAL - 1);
  localparam logic [3:0]  PULSE_MAX = 4'(PULSE_LEN);
  localparam logic [7:0]  TMO       = 8'(TIMEOUT);
  localparam logic [7:0]  NINJ      = 8'(NUM_INJ);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_INJECT  = 3'd2,
    ST_OBSERVE = 3'd3,
    ST_RECOVER = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ivl_q, ivl_d;
  logic [3:0]  pulse_q, pulse_d;
  logic [7:0]  lat_q, lat_d;
  logic [7:0]  inj_cnt_q, inj_cnt_d;
  logic [1:0]  target_q, target_d;
  logic [7:0]  det_q, det_d;
  logic [7:0]  miss_q, miss_d;
  logic [7:0]  spur_q, spur_d;
  logic [7:0]  last_lat_q, last_lat_d;
  logic [2:0]  inj_q, inj_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [2:0]  tgt_mask;
  logic [7:0]  inj_cnt_inc;
  logic        in_busy_state;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] t);
    case (t)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    ivl_d       = ivl_q;
    pulse_d     = pulse_q;
    lat_d       = lat_q;
    inj_cnt_d   = inj_cnt_q;
    target_d    = target_q;
    det_d       = det_q;
    miss_d      = miss_q;
    spur_d      = spur_q;
    last_lat_d  = last_lat_q;
    inj_d       = 3'b000;
    tgt_mask    = onehot(target_q);
    inj_cnt_inc = inj_cnt_q + 8'd1;
    in_busy_state = (state_q == ST_WAIT) || (state_q == ST_INJECT) ||
                    (state_q == ST_OBSERVE) || (state_q == ST_RECOVER);

    // Abort wins over everything else: counts stay as they are and the
    // pulse is dropped on this same edge because inj_d defaults to 0.
    if (in_busy_state && !enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_d    = ST_WAIT;
            ivl_d      = 16'd0;
            inj_cnt_d  = 8'd0;
            target_d   = 2'd0;
            det_d      = 8'd0;
            miss_d     = 8'd0;
            spur_d     = 8'd0;
            last_lat_d = 8'd0;
          end
        end

        ST_WAIT: begin
          // Only quiet cycles count toward the interval.
          if (!core_hold && (Voter_state == 3'b000)) begin
            if (ivl_q == IVL_LAST) begin
              state_d = ST_INJECT;
              ivl_d   = 16'd0;
              pulse_d = 4'd1;
              lat_d   = 8'd1;
              inj_d   = tgt_mask;
            end else begin
              ivl_d = ivl_q + 16'd1;
            end
          end
        end

        ST_INJECT, ST_OBSERVE: begin
          if ((Voter_state & tgt_mask) != 3'b000) begin
            det_d      = sat_inc(det_q);
            last_lat_d = lat_q;
            state_d    = ST_RECOVER;
          end else begin
            if ((Voter_state & ~tgt_mask) != 3'b000) begin
              spur_d = sat_inc(spur_q);
            end
            if (lat_q == TMO) begin
              miss_d  = sat_inc(miss_q);
              state_d = ST_RECOVER;
            end else begin
              lat_d = lat_q + 8'd1;
              if (state_q == ST_INJECT) begin
                // A rising core_hold cuts the pulse short.
                if ((pulse_q == PULSE_MAX) || core_hold) begin
                  state_d = ST_OBSERVE;
                end else begin
                  pulse_d = pulse_q + 4'd1;
                  inj_d   = tgt_mask;
                end
              end
            end
          end
        end

        ST_RECOVER: begin
          if (!core_hold && (Voter_state == 3'b000)) begin
            inj_cnt_d = inj_cnt_inc;
            target_d  = (target_q == 2'd2) ? 2'd0 : target_q + 2'd1;
            state_d   = (inj_cnt_inc == NINJ) ? ST_DONE : ST_WAIT;
          end
        end

        ST_DONE: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_WAIT) || (state_d == ST_INJECT) ||
             (state_d == ST_OBSERVE) || (state_d == ST_RECOVER);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      ivl_q      <= 16'd0;
      pulse_q    <= 4'd0;
      lat_q      <= 8'd0;
      inj_cnt_q  <= 8'd0;
      target_q   <= 2'd0;
      det_q      <= 8'd0;
      miss_q     <= 8'd0;
      spur_q     <= 8'd0;
      last_lat_q <= 8'd0;
      inj_q      <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ivl_q      <= ivl_d;
      pulse_q    <= pulse_d;
      lat_q      <= lat_d;
      inj_cnt_q  <= inj_cnt_d;
      target_q   <= target_d;
      det_q      <= det_d;
      miss_q     <= miss_d;
      spur_q     <= spur_d;
      last_lat_q <= last_lat_d;
      inj_q      <= inj_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign inject_A       = inj_q[0];
  assign inject_B       = inj_q[1];
  assign inject_C       = inj_q[2];
  assign busy           = busy_q;
  assign done           = done_q;
  assign target         = target_q;
  assign detect_count   = det_q;
  assign miss_count     = miss_q;
  assign spurious_count = spur_q;
  assign last_latency   = last_lat_q;

endmodule
